memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
Pipeline stage directly upstream of write-back. It performs data-memory loads/stores, stack PUSH/POP and the two-word CALL/RET transfers. It owns the stack pointer and the MEM/WB pipeline register whose outputs feed write-back's select, immediate, ALU and memory-data inputs.
- Two-word operations stall the upstream pipeline for one cycle.

Parameters:
ADDR_W, 11, data-memory address width in 16-bit words; depth = 2^ADDR_W
SP_INIT, 2^ADDR_W-1, stack pointer value after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ex_valid  in  1  EX/MEM holds a real instruction
ex_mem_op  in  3  NONE=0 LOAD=1 STORE=2 PUSH=3 POP=4 CALL=5 RET=6
ex_addr  in  16  ALU result used as LOAD/STORE address; low ADDR_W bits used
ex_store_data  in  16  STORE/PUSH data
ex_alu_value  in  16  forwarded to wb_alu_value
ex_immediate  in  16  forwarded to wb_immediate
ex_wb_sel  in  2  00 imm, 01 alu, 10 mem
ex_wb_en  in  1  register-file write request
ex_rd  in  3  destination register
ex_outport_en  in  1  OUT instruction
ex_pc_ret  in  32  return PC for CALL
stall  out  1  upstream must hold EX/MEM contents this cycle
wb_valid  out  1  MEM/WB holds a real instruction
wb_sel  out  2  registered ex_wb_sel
wb_en  out  1  registered ex_wb_en & ex_valid
wb_rd  out  3  registered ex_rd
wb_outport_en  out  1  registered ex_outport_en & ex_valid
wb_immediate  out  16  registered
wb_alu_value  out  16  registered
wb_mem_data  out  16  registered memory read data
pc_load  out  1  one-cycle pulse: load pc_target into PC
pc_target  out  32  popped return address
sp_value  out  ADDR_W  current stack pointer

Behaviour:
- Reset (rst=0, asynchronous): SP=SP_INIT; state=IDLE; all wb_* outputs, pc_load, pc_target and stall are 0. Memory contents are not reset.
- Memory read is combinational on the word address and is captured into wb_mem_data at the clock edge. Writes are synchronous on the rising edge.
- Stack is full-descending: SP points to the next free word. All SP arithmetic wraps modulo 2^ADDR_W.
- Single-cycle ops, in IDLE with ex_valid=1. MEM/WB is loaded at the same edge.
  - LOAD: wb_mem_data = mem[ex_addr].
  - STORE: mem[ex_addr] <= ex_store_data.
  - PUSH: mem[SP] <= ex_store_data; SP <= SP-1.
  - POP: wb_mem_data = mem[SP+1]; SP <= SP+1.
  - NONE: pass-through only.
- CALL, two cycles:
  - C1, IDLE: mem[SP] <= ex_pc_ret[31:16]; SP <= SP-1; stall=1; wb_valid <= 0 (bubble); go to CALL2.
  - C2, CALL2: mem[SP] <= ex_pc_ret[15:0]; SP <= SP-1; stall=0; wb_valid <= 1 with wb_en=0; go to IDLE.
- RET, two cycles:
  - R1, IDLE: low word = mem[SP+1] into an internal register; SP <= SP+1; stall=1; bubble; go to RET2.
  - R2, RET2: pc_target <= {mem[SP+1], low}; SP <= SP+1; pc_load <= 1 for exactly one cycle; stall=0; wb_valid <= 1, wb_en=0; go to IDLE.
  - pc_target holds its value until the next RET.
- ex_valid=0 in IDLE: bubble. wb_valid, wb_en and wb_outport_en are 0; SP and memory are unchanged.
- stall is combinational and is 1 only in the first cycle of CALL/RET. EX/MEM inputs are stable during the second cycle because upstream holds them.
- Back-to-back: a new op accepted the cycle after CALL2/RET2 uses the updated SP. PUSH followed immediately by POP returns the pushed value.
- STORE then LOAD at the same address on consecutive cycles returns the new data.
- Reset asserted mid-CALL/RET: immediately returns to IDLE with SP=SP_INIT. No pc_load is issued. A partial stack write is allowed to remain in memory.
- Illegal ex_mem_op values 7 and above are treated as NONE.

Decomposition:
- Shared package (cpu_pkg): mem_op encodings, wb_sel encodings (WB_IMM=00, WB_ALU=01, WB_MEM=10), FSM state encoding (IDLE, CALL2, RET2), ADDR_W default.
- One sub-module: data_memory. Single-port, 2^ADDR_W x 16, combinational read, synchronous write-enable.
- SP, FSM and MEM/WB register live in memory_stage.

Test Plan:
- Reset, then release: sp_value=2047, all wb_* = 0, stall=0, pc_load=0.
- STORE addr 0x0010 data 0xBEEF, then LOAD 0x0010 -> wb_mem_data=0xBEEF and wb_sel=10 one cycle after the LOAD is presented.
- PUSH 0x1234, PUSH 0x5678, POP, POP:
  - sp_value after each op: 2046, 2045, 2046, 2047.
  - wb_mem_data sequence: 0x5678, 0x1234.
- CALL with ex_pc_ret=0x0001_00A4, then RET:
  - stall high in the first cycle of each; pushes to 2047 and 2046.
  - Exactly one pc_load pulse with pc_target=0x0001_00A4; sp_value back to 2047.
- SP wrap: from reset, POP -> sp_value=0 and reads mem[0]. Then PUSH -> sp_value=2047.
- Assert rst during CALL2 -> state IDLE, sp_value=2047, no pc_load. A following LOAD works normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the memory stage: memory-op codes, write-back select
// codes, stack-transfer FSM states and the default address width.
package cpu_pkg;

  localparam int ADDR_W_DEF = 11;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4,
    OP_CALL  = 3'd5,
    OP_RET   = 3'd6
  } mem_op_e;

  typedef enum logic [1:0] {
    WB_IMM = 2'b00,
    WB_ALU = 2'b01,
    WB_MEM = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALL2 = 2'd1,
    ST_RET2  = 2'd2
  } state_e;

  // Raw op field to operation; the unused code 7 behaves as NONE.
  function automatic mem_op_e decode_op(input logic [2:0] raw);
    mem_op_e op;
    case (raw)
      3'd1:    op = OP_LOAD;
      3'd2:    op = OP_STORE;
      3'd3:    op = OP_PUSH;
      3'd4:    op = OP_POP;
      3'd5:    op = OP_CALL;
      3'd6:    op = OP_RET;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Single-port data memory, 2^ADDR_W x 16: combinational read, synchronous
// write. Contents are never reset.
module data_memory
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       wdata_i,
  output logic [15:0]       rdata_o
);

  logic [15:0] mem_q [2**ADDR_W];

  // Write port: one word per rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: data loads/stores, stack PUSH/POP and the two-cycle
// CALL/RET return-address transfers. Owns the stack pointer and the MEM/WB
// pipeline register. The stack is full-descending (SP = next free word).
module memory_stage
  import cpu_pkg::*;
#(
  parameter int              ADDR_W  = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [2:0]        ex_mem_op,
  input  logic [15:0]       ex_addr,
  input  logic [15:0]       ex_store_data,
  input  logic [15:0]       ex_alu_value,
  input  logic [15:0]       ex_immediate,
  input  logic [1:0]        ex_wb_sel,
  input  logic              ex_wb_en,
  input  logic [2:0]        ex_rd,
  input  logic              ex_outport_en,
  input  logic [31:0]       ex_pc_ret,
  output logic              stall,
  output logic              wb_valid,
  output logic [1:0]        wb_sel,
  output logic              wb_en,
  output logic [2:0]        wb_rd,
  output logic              wb_outport_en,
  output logic [15:0]       wb_immediate,
  output logic [15:0]       wb_alu_value,
  output logic [15:0]       wb_mem_data,
  output logic              pc_load,
  output logic [31:0]       pc_target,
  output logic [ADDR_W-1:0] sp_value
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] sp_inc, sp_dec;
  logic [15:0]       ret_lo_q, ret_lo_d;
  logic [31:0]       pc_target_q, pc_target_d;
  logic              pc_load_q, pc_load_d;

  logic              wb_valid_q, wb_valid_d;
  logic [1:0]        wb_sel_q, wb_sel_d;
  logic              wb_en_q, wb_en_d;
  logic [2:0]        wb_rd_q, wb_rd_d;
  logic              wb_outport_q, wb_outport_d;
  logic [15:0]       wb_imm_q, wb_imm_d;
  logic [15:0]       wb_alu_q, wb_alu_d;
  logic [15:0]       wb_mem_data_q, wb_mem_data_d;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;

  mem_op_e           op;
  logic              two_word_start;
  logic              unused_addr_hi;

  assign op             = decode_op(ex_mem_op);
  assign sp_inc         = sp_q + ADDR_W'(1);
  assign sp_dec         = sp_q - ADDR_W'(1);
  assign unused_addr_hi = ^ex_addr[15:ADDR_W];

  // Only the first cycle of CALL/RET holds the upstream pipeline.
  assign two_word_start = (state_q == ST_IDLE) && ex_valid &&
                          ((op == OP_CALL) || (op == OP_RET));
  assign stall          = rst && two_word_start;

  data_memory #(
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  // Memory port steering: address, write enable and write data per op/state.
  always_comb begin
    mem_addr  = ex_addr[ADDR_W-1:0];
    mem_we    = 1'b0;
    mem_wdata = ex_store_data;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          case (op)
            OP_STORE: mem_we = 1'b1;
            OP_PUSH: begin
              mem_addr = sp_q;
              mem_we   = 1'b1;
            end
            OP_POP, OP_RET: mem_addr = sp_inc;
            OP_CALL: begin
              mem_addr  = sp_q;
              mem_we    = 1'b1;
              mem_wdata = ex_pc_ret[31:16];
            end
            default: ;
          endcase
        end
      end
      ST_CALL2: begin
        mem_addr  = sp_q;
        mem_we    = 1'b1;
        mem_wdata = ex_pc_ret[15:0];
      end
      ST_RET2: mem_addr = sp_inc;
      default: ;
    endcase
    // No stray writes while the stage is held in reset.
    if (!rst) mem_we = 1'b0;
  end

  // Next-state logic: FSM, stack pointer, return-address capture, MEM/WB.
  always_comb begin
    state_d       = state_q;
    sp_d          = sp_q;
    ret_lo_d      = ret_lo_q;
    pc_target_d   = pc_target_q;
    pc_load_d     = 1'b0;
    wb_valid_d    = 1'b0;
    wb_en_d       = 1'b0;
    wb_outport_d  = 1'b0;
    wb_sel_d      = ex_wb_sel;
    wb_rd_d       = ex_rd;
    wb_imm_d      = ex_immediate;
    wb_alu_d      = ex_alu_value;
    wb_mem_data_d = mem_rdata;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          wb_valid_d   = 1'b1;
          wb_en_d      = ex_wb_en;
          wb_outport_d = ex_outport_en;
          case (op)
            OP_PUSH: sp_d = sp_dec;
            OP_POP:  sp_d = sp_inc;
            OP_CALL: begin
              sp_d         = sp_dec;
              wb_valid_d   = 1'b0;
              wb_en_d      = 1'b0;
              wb_outport_d = 1'b0;
              state_d      = ST_CALL2;
            end
            OP_RET: begin
              ret_lo_d     = mem_rdata;
              sp_d         = sp_inc;
              wb_valid_d   = 1'b0;
              wb_en_d      = 1'b0;
              wb_outport_d = 1'b0;
              state_d      = ST_RET2;
            end
            default: ;
          endcase
        end
      end
      ST_CALL2: begin
        sp_d       = sp_dec;
        wb_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_RET2: begin
        pc_target_d = {mem_rdata, ret_lo_q};
        pc_load_d   = 1'b1;
        sp_d        = sp_inc;
        wb_valid_d  = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, SP, PC redirect and MEM/WB register with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      sp_q          <= SP_INIT;
      pc_target_q   <= '0;
      pc_load_q     <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_sel_q      <= '0;
      wb_en_q       <= 1'b0;
      wb_rd_q       <= '0;
      wb_outport_q  <= 1'b0;
      wb_imm_q      <= '0;
      wb_alu_q      <= '0;
      wb_mem_data_q <= '0;
    end else begin
      state_q       <= state_d;
      sp_q          <= sp_d;
      pc_target_q   <= pc_target_d;
      pc_load_q     <= pc_load_d;
      wb_valid_q    <= wb_valid_d;
      wb_sel_q      <= wb_sel_d;
      wb_en_q       <= wb_en_d;
      wb_rd_q       <= wb_rd_d;
      wb_outport_q  <= wb_outport_d;
      wb_imm_q      <= wb_imm_d;
      wb_alu_q      <= wb_alu_d;
      wb_mem_data_q <= wb_mem_data_d;
    end
  end

  // Low return-address word held between the two RET cycles.
  always_ff @(posedge clk) begin
    ret_lo_q <= ret_lo_d;
  end

  assign wb_valid      = wb_valid_q;
  assign wb_sel        = wb_sel_q;
  assign wb_en         = wb_en_q;
  assign wb_rd         = wb_rd_q;
  assign wb_outport_en = wb_outport_q;
  assign wb_immediate  = wb_imm_q;
  assign wb_alu_value  = wb_alu_q;
  assign wb_mem_data   = wb_mem_data_q;
  assign pc_load       = pc_load_q;
  assign pc_target     = pc_target_q;
  assign sp_value      = sp_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios followed by random
// operations, compared against a word-array/stack-pointer reference model.
module tb_memory_stage;

  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic [2:0]  ex_mem_op = '0;
  logic [15:0] ex_addr = '0;
  logic [15:0] ex_store_data = '0;
  logic [15:0] ex_alu_value = '0;
  logic [15:0] ex_immediate = '0;
  logic [1:0]  ex_wb_sel = '0;
  logic        ex_wb_en = 1'b0;
  logic [2:0]  ex_rd = '0;
  logic        ex_outport_en = 1'b0;
  logic [31:0] ex_pc_ret = '0;
  logic        stall, wb_valid, wb_en, wb_outport_en, pc_load;
  logic [1:0]  wb_sel;
  logic [2:0]  wb_rd;
  logic [15:0] wb_immediate, wb_alu_value, wb_mem_data;
  logic [31:0] pc_target;
  logic [10:0] sp_value;

  int errors = 0;
  int checks = 0;

  logic [15:0] mdl_mem [DEPTH];
  int unsigned mdl_sp = DEPTH - 1;
  logic [31:0] mdl_pc_target = '0;

  memory_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_mem_op     (ex_mem_op),
    .ex_addr       (ex_addr),
    .ex_store_data (ex_store_data),
    .ex_alu_value  (ex_alu_value),
    .ex_immediate  (ex_immediate),
    .ex_wb_sel     (ex_wb_sel),
    .ex_wb_en      (ex_wb_en),
    .ex_rd         (ex_rd),
    .ex_outport_en (ex_outport_en),
    .ex_pc_ret     (ex_pc_ret),
    .stall         (stall),
    .wb_valid      (wb_valid),
    .wb_sel        (wb_sel),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_outport_en (wb_outport_en),
    .wb_immediate  (wb_immediate),
    .wb_alu_value  (wb_alu_value),
    .wb_mem_data   (wb_mem_data),
    .pc_load       (pc_load),
    .pc_target     (pc_target),
    .sp_value      (sp_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sp_down();
    mdl_sp = (mdl_sp + DEPTH - 1) % DEPTH;
  endtask

  task automatic sp_up();
    mdl_sp = (mdl_sp + 1) % DEPTH;
  endtask

  // Hold reset for a cycle and check every output's reset value.
  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    ex_valid = 1'b0;
    #1;
    chk("rst sp", 32'(sp_value), 32'(DEPTH - 1));
    chk("rst wb_valid", 32'(wb_valid), 32'd0);
    chk("rst wb_en", 32'(wb_en), 32'd0);
    chk("rst wb_outport_en", 32'(wb_outport_en), 32'd0);
    chk("rst wb_sel", 32'(wb_sel), 32'd0);
    chk("rst wb_rd", 32'(wb_rd), 32'd0);
    chk("rst wb_immediate", 32'(wb_immediate), 32'd0);
    chk("rst wb_alu_value", 32'(wb_alu_value), 32'd0);
    chk("rst wb_mem_data", 32'(wb_mem_data), 32'd0);
    chk("rst pc_load", 32'(pc_load), 32'd0);
    chk("rst pc_target", pc_target, 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mdl_sp = DEPTH - 1;
    mdl_pc_target = '0;
  endtask

  // One single-cycle operation (or bubble when v=0); op 7 acts as NONE.
  task automatic single(input logic v, input logic [2:0] op, input logic [15:0] addr,
                        input logic [15:0] d, input logic [1:0] sel);
    logic        wben, oe;
    logic [2:0]  rd;
    logic [15:0] alu, imm, expd;
    bit          chkd;
    wben = 1'($urandom_range(0, 1));
    oe   = 1'($urandom_range(0, 1));
    rd   = 3'($urandom_range(0, 7));
    alu  = 16'($urandom_range(0, 65535));
    imm  = 16'($urandom_range(0, 65535));
    expd = '0;
    chkd = 0;
    @(negedge clk);
    ex_valid = v; ex_mem_op = op; ex_addr = addr; ex_store_data = d;
    ex_wb_sel = sel; ex_wb_en = wben; ex_rd = rd; ex_outport_en = oe;
    ex_alu_value = alu; ex_immediate = imm;
    #1;
    chk("single stall", 32'(stall), 32'd0);
    if (v) begin
      case (op)
        3'd1: begin expd = mdl_mem[int'(addr[10:0])]; chkd = 1; end
        3'd2: mdl_mem[int'(addr[10:0])] = d;
        3'd3: begin mdl_mem[mdl_sp] = d; sp_down(); end
        3'd4: begin sp_up(); expd = mdl_mem[mdl_sp]; chkd = 1; end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    chk("wb_valid", 32'(wb_valid), 32'(v));
    chk("wb_en", 32'(wb_en), 32'(v & wben));
    chk("wb_outport_en", 32'(wb_outport_en), 32'(v & oe));
    chk("sp", 32'(sp_value), mdl_sp);
    chk("pc_load idle", 32'(pc_load), 32'd0);
    chk("pc_target hold", pc_target, mdl_pc_target);
    if (v) begin
      chk("wb_sel", 32'(wb_sel), 32'(sel));
      chk("wb_rd", 32'(wb_rd), 32'(rd));
      chk("wb_immediate", 32'(wb_immediate), 32'(imm));
      chk("wb_alu_value", 32'(wb_alu_value), 32'(alu));
    end
    if (chkd) chk("wb_mem_data", 32'(wb_mem_data), 32'(expd));
  endtask

  task automatic do_call(input logic [31:0] pc);
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_op = 3'd5; ex_pc_ret = pc; ex_wb_en = 1'b1;
    #1;
    chk("call1 stall", 32'(stall), 32'd1);
    mdl_mem[mdl_sp] = pc[31:16];
    sp_down();
    @(posedge clk);
    #1;
    chk("call1 wb_valid", 32'(wb_valid), 32'd0);
    chk("call1 wb_en", 32'(wb_en), 32'd0);
    chk("call1 sp", 32'(sp_value), mdl_sp);
    chk("call1 pc_load", 32'(pc_load), 32'd0);
    @(negedge clk);
    #1;
    chk("call2 stall", 32'(stall), 32'd0);
    mdl_mem[mdl_sp] = pc[15:0];
    sp_down();
    @(posedge clk);
    #1;
    chk("call2 wb_valid", 32'(wb_valid), 32'd1);
    chk("call2 wb_en", 32'(wb_en), 32'd0);
    chk("call2 sp", 32'(sp_value), mdl_sp);
    chk("call2 pc_load", 32'(pc_load), 32'd0);
  endtask

  task automatic do_ret();
    logic [15:0] lo, hi;
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_op = 3'd6; ex_wb_en = 1'b1;
    #1;
    chk("ret1 stall", 32'(stall), 32'd1);
    sp_up();
    lo = mdl_mem[mdl_sp];
    @(posedge clk);
    #1;
    chk("ret1 wb_valid", 32'(wb_valid), 32'd0);
    chk("ret1 sp", 32'(sp_value), mdl_sp);
    chk("ret1 pc_load", 32'(pc_load), 32'd0);
    @(negedge clk);
    #1;
    chk("ret2 stall", 32'(stall), 32'd0);
    sp_up();
    hi = mdl_mem[mdl_sp];
    mdl_pc_target = {hi, lo};
    @(posedge clk);
    #1;
    chk("ret2 pc_load", 32'(pc_load), 32'd1);
    chk("ret2 pc_target", pc_target, mdl_pc_target);
    chk("ret2 wb_valid", 32'(wb_valid), 32'd1);
    chk("ret2 wb_en", 32'(wb_en), 32'd0);
    chk("ret2 sp", 32'(sp_value), mdl_sp);
  endtask

  initial begin
    // Reset values, then one idle cycle after release.
    #12;
    do_reset();
    single(1'b0, 3'd0, 16'h0, 16'h0, 2'b00);

    // Give every memory word a known value so later reads are predictable.
    for (int a = 0; a < DEPTH; a++)
      single(1'b1, 3'd2, 16'(a), 16'(a) ^ 16'hA5A5, 2'b01);

    // STORE then LOAD at the same address on consecutive cycles.
    single(1'b1, 3'd2, 16'h0010, 16'hBEEF, 2'b01);
    single(1'b1, 3'd1, 16'h0010, 16'h0000, 2'b10);
    chk("load beef data", 32'(wb_mem_data), 32'h0000BEEF);
    chk("load beef sel", 32'(wb_sel), 32'd2);

    // PUSH, PUSH, POP, POP.
    single(1'b1, 3'd3, 16'h0, 16'h1234, 2'b10);
    chk("push1 sp", 32'(sp_value), 32'd2046);
    single(1'b1, 3'd3, 16'h0, 16'h5678, 2'b10);
    chk("push2 sp", 32'(sp_value), 32'd2045);
    single(1'b1, 3'd4, 16'h0, 16'h0, 2'b10);
    chk("pop1 sp", 32'(sp_value), 32'd2046);
    chk("pop1 data", 32'(wb_mem_data), 32'h5678);
    single(1'b1, 3'd4, 16'h0, 16'h0, 2'b10);
    chk("pop2 sp", 32'(sp_value), 32'd2047);
    chk("pop2 data", 32'(wb_mem_data), 32'h1234);

    // CALL then RET restores the return address and SP.
    do_call(32'h0001_00A4);
    chk("call sp", 32'(sp_value), 32'd2045);
    do_ret();
    chk("ret target", pc_target, 32'h0001_00A4);
    chk("ret sp", 32'(sp_value), 32'd2047);
    single(1'b0, 3'd0, 16'h0, 16'h0, 2'b00);

    // SP wraps both ways.
    do_reset();
    single(1'b1, 3'd4, 16'h0, 16'h0, 2'b10);
    chk("wrap pop sp", 32'(sp_value), 32'd0);
    chk("wrap pop data", 32'(wb_mem_data), 32'(mdl_mem[0]));
    single(1'b1, 3'd3, 16'h0, 16'h4321, 2'b10);
    chk("wrap push sp", 32'(sp_value), 32'd2047);

    // Reset asserted during the second CALL cycle.
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_op = 3'd5; ex_pc_ret = 32'hDEAD_BEEF;
    #1;
    chk("rcall stall", 32'(stall), 32'd1);
    mdl_mem[mdl_sp] = 16'hDEAD;
    sp_down();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rcall sp", 32'(sp_value), 32'd2047);
    chk("rcall pc_load", 32'(pc_load), 32'd0);
    chk("rcall stall rst", 32'(stall), 32'd0);
    chk("rcall wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    ex_valid = 1'b0;
    rst = 1'b1;
    mdl_sp = DEPTH - 1;
    mdl_pc_target = '0;
    single(1'b0, 3'd0, 16'h0, 16'h0, 2'b00);
    single(1'b1, 3'd1, 16'h0010, 16'h0, 2'b10);
    chk("post rst load", 32'(wb_mem_data), 32'h0000BEEF);

    // Random mix of operations, bubbles and illegal op codes.
    for (int i = 0; i < 400; i++) begin
      int unsigned k;
      logic v;
      k = $urandom_range(0, 11);
      v = ($urandom_range(0, 9) != 0);
      case (k)
        0, 1:   single(v, 3'd1, 16'($urandom_range(0, 65535)), 16'h0, 2'($urandom_range(0, 2)));
        2, 3:   single(v, 3'd2, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 2'($urandom_range(0, 2)));
        4, 5:   single(v, 3'd3, 16'h0, 16'($urandom_range(0, 65535)), 2'($urandom_range(0, 2)));
        6, 7:   single(v, 3'd4, 16'h0, 16'h0, 2'($urandom_range(0, 2)));
        8:      single(v, 3'd0, 16'($urandom_range(0, 65535)), 16'h0, 2'($urandom_range(0, 2)));
        9:      single(v, 3'd7, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 2'($urandom_range(0, 2)));
        10:     do_call(32'($urandom));
        default: do_ret();
      endcase
    end
    single(1'b0, 3'd0, 16'h0, 16'h0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
